// File: rtl/program_load_sequencer.sv
// Program load sequencer: streams a program into instruction memory,
// then gates reset and pipeline advance of the core (run/step/halt).
module program_load_sequencer #(
  parameter int IMEM_DEPTH = 32,
  parameter int ADDR_W     = 5,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load_Valid,
  input  logic [7:0]         Load_Data,
  input  logic               Load_Last,
  output logic               Load_Ready,
  input  logic               Start,
  input  logic               Step,
  input  logic               Halt,
  input  logic               Clear,
  output logic               Imem_We,
  output logic [ADDR_W-1:0]  Imem_Addr,
  output logic [7:0]         Imem_Wdata,
  output logic               Core_Reset,
  output logic               Core_Clk_En,
  output logic [2:0]         State,
  output logic [ADDR_W:0]    Load_Count,
  output logic [CYCLE_W-1:0] Cycle_Count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]  ONE_L   = (ADDR_W+1)'(1);
  localparam logic [CYCLE_W:0] MAX_C   = (CYCLE_W+1)'(MAX_CYCLES);
  localparam bit               LIM_EN  = (MAX_CYCLES != 0);

  state_t               r_state, w_next;
  logic [ADDR_W:0]      r_lcnt, w_lcnt_nx, w_lcnt_inc;
  logic [CYCLE_W-1:0]   r_ccnt, w_ccnt_nx, w_ccnt_inc;
  logic                 r_ready, r_we, r_crst, r_cen;
  logic [ADDR_W-1:0]    r_addr;
  logic [7:0]           r_wdata;
  logic                 w_xfer, w_at_lim, w_hit;

  assign w_xfer     = Load_Valid && r_ready && (r_state == S_IDLE);
  assign w_lcnt_inc = r_lcnt + ONE_L;
  assign w_ccnt_inc = (&r_ccnt) ? r_ccnt : r_ccnt + 1'b1;
  // at_lim blocks restart; hit ends a run on the edge the limit is reached
  assign w_at_lim   = LIM_EN && ({1'b0, r_ccnt} >= MAX_C);
  assign w_hit      = LIM_EN && r_cen && ({1'b0, w_ccnt_inc} >= MAX_C);

  always_comb begin
    w_next    = r_state;
    w_lcnt_nx = r_lcnt;
    w_ccnt_nx = r_cen ? w_ccnt_inc : r_ccnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_lcnt_nx = w_lcnt_inc;
          if (Load_Last || (w_lcnt_inc == DEPTH_C))
            w_next = S_READY;
        end
      end
      S_READY, S_HALT: begin
        if (Clear) begin
          w_next    = S_IDLE;
          w_lcnt_nx = '0;
          w_ccnt_nx = '0;
        end else if (Start && !w_at_lim) begin
          w_next = S_RUN;
        end else if (Step) begin
          w_next = S_STEP;
        end
      end
      S_RUN: begin
        if (Clear) begin
          w_next    = S_IDLE;
          w_lcnt_nx = '0;
          w_ccnt_nx = '0;
        end else if (Halt || w_hit) begin
          w_next = S_HALT;
        end
      end
      S_STEP: begin
        if (Clear) begin
          w_next    = S_IDLE;
          w_lcnt_nx = '0;
          w_ccnt_nx = '0;
        end else begin
          w_next = S_HALT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_lcnt  <= '0;
      r_ccnt  <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_crst  <= 1'b1;
      r_cen   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lcnt  <= w_lcnt_nx;
      r_ccnt  <= w_ccnt_nx;
      r_we    <= w_xfer;
      if (w_xfer) begin
        r_addr  <= r_lcnt[ADDR_W-1:0];
        r_wdata <= Load_Data;
      end
      r_ready <= (w_next == S_IDLE) && (w_lcnt_nx < DEPTH_C);
      r_crst  <= (w_next == S_IDLE) || (w_next == S_READY);
      r_cen   <= (w_next == S_RUN) || (w_next == S_STEP);
    end
  end

  assign State       = r_state;
  assign Load_Ready  = r_ready;
  assign Imem_We     = r_we;
  assign Imem_Addr   = r_addr;
  assign Imem_Wdata  = r_wdata;
  assign Core_Reset  = r_crst;
  assign Core_Clk_En = r_cen;
  assign Load_Count  = r_lcnt;
  assign Cycle_Count = r_ccnt;

endmodule

// File: doc/program_load_sequencer.md
PROGRAM_LOAD_SEQUENCER -- requirements
Module: program_load_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32, instruction-memory size in bytes (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 5, log2(IMEM_DEPTH).
REQ-003 SHALL have parameter CYCLE_W, default 16, width of the run-cycle counter.
REQ-004 SHALL have parameter MAX_CYCLES, default 0, auto-halt cycle limit; 0 means no limit.
REQ-005 SHALL have port Clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Load_Valid  input  1  a program byte is presented.
REQ-008 SHALL have port Load_Data  input  8  program byte (8-bit instruction code).
REQ-009 SHALL have port Load_Last  input  1  qualifies Load_Valid; marks the final byte.
REQ-010 SHALL have port Load_Ready  output  1  sequencer accepts a byte this cycle.
REQ-011 SHALL have ports Start, Step, Halt, Clear  input  1 each  level-sampled command strobes.
REQ-012 SHALL have port Imem_We  output  1  instruction-memory write enable.
REQ-013 SHALL have port Imem_Addr  output  ADDR_W  instruction-memory write address.
REQ-014 SHALL have port Imem_Wdata  output  8  instruction-memory write data.
REQ-015 SHALL have port Core_Reset  output  1  active-high hold-in-reset to the pipelined core.
REQ-016 SHALL have port Core_Clk_En  output  1  pipeline advance enable to the core.
REQ-017 SHALL have port State  output  3  current state encoding.
REQ-018 SHALL have port Load_Count  output  ADDR_W+1  bytes loaded.
REQ-019 SHALL have port Cycle_Count  output  CYCLE_W  core cycles executed.

Function
REQ-020 SHALL implement states IDLE=0, READY=1, RUN=2, STEP=3, HALT=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-021 SHALL register every output; no combinational input-to-output path except none.
REQ-022 In IDLE, Load_Ready SHALL be 1 while Load_Count < IMEM_DEPTH, else 0; in all other states 0.
REQ-023 A transfer (Load_Valid && Load_Ready) SHALL, on the next cycle, drive Imem_We=1, Imem_Addr=Load_Count (pre-increment), Imem_Wdata=Load_Data, and increment Load_Count.
REQ-024 Imem_We SHALL be 0 in every cycle not following a transfer.
REQ-025 Transfer with Load_Last=1, or transfer that makes Load_Count equal IMEM_DEPTH, SHALL move IDLE->READY; Load_Valid outside IDLE SHALL be ignored.
REQ-026 In IDLE and READY: Core_Reset=1, Core_Clk_En=0.
REQ-027 READY or HALT with Start SHALL enter RUN; in RUN Core_Reset=0, Core_Clk_En=1.
REQ-028 READY or HALT with Step (no Start) SHALL enter STEP for exactly one cycle with Core_Reset=0, Core_Clk_En=1, then HALT.
REQ-029 RUN with Halt SHALL enter HALT; in HALT Core_Reset=0, Core_Clk_En=0 (core state frozen).
REQ-030 Cycle_Count SHALL increment by 1 in every cycle Core_Clk_En=1 and saturate at all-ones.
REQ-031 If MAX_CYCLES!=0, RUN SHALL enter HALT on the edge at which Cycle_Count becomes MAX_CYCLES; Start from HALT at the limit SHALL be ignored.
REQ-032 Clear in READY, RUN, STEP or HALT SHALL enter IDLE and zero Load_Count and Cycle_Count; Core_Reset=1 from the next cycle.
REQ-033 Simultaneous commands SHALL resolve Clear > Halt > Start > Step; commands invalid in the current state SHALL be ignored.
REQ-034 Start/Step in IDLE SHALL be ignored, including IDLE with Load_Count=0.

Reset
REQ-035 Reset low SHALL asynchronously force State=IDLE, Load_Ready=0, Imem_We=0, Imem_Addr=0, Imem_Wdata=0, Core_Reset=1, Core_Clk_En=0, Load_Count=0, Cycle_Count=0.
REQ-036 Load_Ready SHALL first rise on the first edge after Reset deasserts; reset mid-load or mid-run SHALL discard all progress with no further Imem_We.

Verification
REQ-037 Load 3 bytes 0x45,0x12,0xC3 (last flagged) -> Imem_We pulses at addr 0,1,2 with matching data, Load_Count=3, State=READY, Core_Reset=1.
REQ-038 Load 40 bytes without Load_Last, DEPTH=32 -> 32 writes (addr 0..31), Load_Ready=0 after 32nd, State=READY, bytes 33..40 ignored.
REQ-039 READY, Start, 10 cycles, Halt -> Core_Clk_En high 10 cycles, Cycle_Count=10, State=HALT, Core_Reset=0.
REQ-040 HALT, Step twice (separated) -> two single-cycle Core_Clk_En pulses, Cycle_Count +2, State returns HALT each time.
REQ-041 MAX_CYCLES=5, Start -> HALT after 5 enabled cycles, Cycle_Count=5; later Start ignored; Clear+Halt same cycle -> IDLE, counts 0.
REQ-042 Reset asserted during RUN -> all outputs at reset values immediately, without waiting for Clk.
